gps_ser_gather: RTL and testbench
=================================

# gps_ser_gather

Bit-serial readout gatherer sitting directly downstream of the GPS core's `ser`/`rdBit` interface. After the host has issued the `rdReg` that loads a GPS serial source (SRQ flags, clock-replica snapshot or channel IQ), this block runs that source out at one bit per clock. It generates the `rdBit` strobes itself, packs the bits MSB-first into 16-bit words, and queues the words in a small first-word-fall-through FIFO for the CPU. The CPU then reads whole words instead of issuing one `rdBit` per bit.

## Interface
Parameters:
- `DEPTH`, 16, FIFO depth in words; power of 2, ≥2.
- `NB_W`, 10, width of the bit-count field; the maximum transfer is 2^NB_W−1 bits.

Ports:
- `clk`  in  1  system clock; same domain as the GPS core.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a transfer.
- `nbits`  in  NB_W  number of bits to gather; sampled on `start`.
- `abort`  in  1  pulse that ends the transfer and empties the FIFO.
- `ser`  in  1  serial bit from the GPS core (current MSB of the selected source).
- `rd_bit`  out  1  shift strobe to the GPS core's `rdBit`.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse after the last bit has been captured.
- `dout`  out  16  FIFO head word.
- `dout_valid`  out  1  FIFO not empty.
- `dout_rd`  in  1  pop the FIFO head.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `csum`  out  16  running checksum (see Configuration).

## Operation
- States:
  - IDLE → RUN on `start` with `nbits`≠0.
  - RUN → IDLE on the cycle the last bit is captured, or on `abort`.
  - `start` with `nbits`=0 is ignored: no `done`, state stays IDLE.
  - `start` while in RUN is ignored.
- Sequencing: on `start`, latch `nbits` into the remaining-bit counter, clear the 16-bit shift register and clear the 4-bit in-word counter.
- `rd_bit` = RUN & ~FIFO-full & ~`rst` & ~`abort`. This is combinational; there is no registered output on this path.
- On each clock edge with `rd_bit` high:
  - shift register ← {sreg[14:0], `ser`};
  - decrement the remaining count;
  - increment the in-word count.
  - The GPS core shifts its source on the same edge, so the next bit is valid in the following cycle.
- Word push, in the same edge as the capturing bit:
  - When the 16th bit of a word is captured, push {sreg[14:0], `ser`} and clear the shift register.
  - When the final bit of the transfer is captured, push the same value even if fewer than 16 bits have been collected. The final partial word is therefore right-justified: its last bit is at [0] and the unused upper bits are zero.
- FIFO:
  - First-word-fall-through: `dout` = head word, `dout_valid` = ~empty.
  - `dout_rd` while empty is ignored.
  - A push and a pop in the same cycle are both performed.
  - A push is never attempted while the FIFO is full, because the full flag blocks `rd_bit`.
- `abort` or `rst`:
  - state → IDLE; FIFO emptied; counters and shift register cleared; `csum` cleared.
  - No `done` pulse is produced.
  - Already-popped data is unaffected.
- Caller rule: the GPS core's `rdReg` must come at least 1 cycle before `start`, so that `ser` is valid in the first RUN cycle.

## Timing
- Reset values: `rd_bit`=0, `busy`=0, `done`=0, `dout_valid`=0, `level`=0, `dout`=0, `csum`=0.
- `start` at edge N:
  - `busy`=1 and `rd_bit`=1 in cycle N+1 (provided the FIFO is not full);
  - bit k is captured at edge N+1+k, with no stall;
  - throughput is 1 bit/clk.
- Last bit captured at edge M:
  - `busy`=0 and `done`=1 in cycle M+1;
  - the final word is visible in `level`/`dout_valid` in cycle M+1.
- FIFO-full stall:
  - `rd_bit` drops in the same cycle that `level`=DEPTH;
  - after a pop, `rd_bit` resumes the cycle after the pop edge;
  - no bits are lost or duplicated.
- `rst` or `abort` high in cycle C: `rd_bit`=0 in cycle C; all state is cleared from cycle C+1.

## Configuration
- `GPS_SER_GATHER_CSUM_EN` defined:
  - `csum` = XOR of every word pushed since the last `start`/`abort`/`rst`;
  - it is updated on the push edge and cleared on `start`.
- `GPS_SER_GATHER_CSUM_EN` undefined: `csum` is tied to 16'h0000 and no checksum logic is built.

## Test plan
- `nbits`=16, `ser` stream 0xA5C3 MSB-first, no stalls → `rd_bit` high for exactly 16 consecutive cycles; `dout`=0xA5C3; `level`=1; `done` pulses once in the cycle after the 16th capture.
- `nbits`=20, stream 0x1234 followed by bits 1011 → FIFO holds 0x1234 then 0x000B; `done` in the cycle after the 20th capture.
- `DEPTH`=4, `nbits`=96, no pops → `rd_bit` stops after 64 bits while `busy`=1; pop one word → `rd_bit` resumes the next cycle; after 96 bits 6 words total are read, in order and intact.
- `start` with `nbits`=0 → `rd_bit`, `busy` and `done` all stay 0. A second `start` issued during RUN → ignored; the bit count of the first transfer is preserved.
- `rst` asserted after 7 bits of a 32-bit transfer → `rd_bit`=0 in the `rst` cycle; next cycle `busy`=0, `dout_valid`=0, `level`=0. A subsequent `nbits`=16 transfer completes normally.
- Macro defined, words 0x1234 then 0x00FF → `csum`=0x12CB; `abort` → `csum`=0 and FIFO empty. Macro undefined → `csum`=0 throughout.

Source files
------------

// File: rtl/gps_ser_gather.sv
// gps_ser_gather: drives rdBit on the GPS serial source, packs bits
// MSB-first into 16-bit words and queues them in a FWFT FIFO.
// Ports: clk/rst (sync, active-high), start/nbits/abort control,
//   ser in, rd_bit strobe out, busy/done status, dout/dout_valid/
//   dout_rd FIFO head and pop, level occupancy, csum checksum.
// Optional macro GPS_SER_GATHER_CSUM_EN builds the XOR checksum;
//   otherwise csum is tied to zero.
module gps_ser_gather #(
   parameter int DEPTH = 16,
   parameter int NB_W  = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [NB_W-1:0]          nbits,
   input  logic                     abort,
   input  logic                     ser,
   output logic                     rd_bit,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              dout,
   output logic                     dout_valid,
   input  logic                     dout_rd,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              csum
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [NB_W-1:0]   r_rem;
   logic [3:0]        r_wcnt;
   logic [15:0]       r_sreg;
   logic [15:0]       r_mem [DEPTH];
   logic [AW-1:0]     r_wp;
   logic [AW-1:0]     r_rp;
   logic [AW:0]       r_cnt;
   logic              r_done;

   logic              w_full;
   logic              w_start;
   logic              w_clr;
   logic              w_last;
   logic              w_push;
   logic              w_pop;
   logic [15:0]       w_word;

   assign w_full  = (r_cnt == L_FULL);
   assign w_clr   = rst | abort;
   assign w_start = start & (nbits != '0)
                  & (r_state == S_IDLE) & ~abort;
   // The full flag gates the strobe, so a push never hits a full FIFO.
   assign rd_bit  = (r_state == S_RUN) & ~w_full & ~rst & ~abort;
   assign w_word  = {r_sreg[14:0], ser};
   assign w_last  = rd_bit & (r_rem == NB_W'(1));
   // A word completes on its 16th bit or on the final bit of the transfer.
   assign w_push  = rd_bit & ((r_wcnt == 4'hF) | (r_rem == NB_W'(1)));
   assign w_pop   = dout_rd & (r_cnt != '0);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_start) w_next = S_RUN;
         S_RUN:  if (abort || w_last) w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_rem  <= '0;
         r_wcnt <= '0;
         r_sreg <= '0;
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_start) begin
            r_rem  <= nbits;
            r_wcnt <= '0;
            r_sreg <= '0;
         end else if (rd_bit) begin
            r_rem  <= r_rem - NB_W'(1);
            r_wcnt <= r_wcnt + 4'd1;
            r_sreg <= w_push ? 16'h0000 : w_word;
         end
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push}
                        - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= w_word;
   end

`ifdef GPS_SER_GATHER_CSUM_EN
   logic [15:0] r_csum;

   always_ff @(posedge clk) begin
      if (w_clr || w_start) r_csum <= 16'h0000;
      else if (w_push)      r_csum <= r_csum ^ w_word;
   end

   assign csum = r_csum;
`else
   assign csum = 16'h0000;
`endif

   assign busy       = (r_state == S_RUN);
   assign done       = r_done;
   assign dout_valid = (r_cnt != '0);
   // Gate the head so an empty FIFO reads as zero.
   assign dout       = dout_valid ? r_mem[r_rp] : 16'h0000;
   assign level      = r_cnt;

endmodule

// File: tb/tb_gps_ser_gather.sv
// tb_gps_ser_gather: randomized bench for gps_ser_gather with a
// behavioural GPS source and a word-chunking reference model.
module tb_gps_ser_gather;

   localparam int DEPTH = 4;
   localparam int NB_W  = 10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [NB_W-1:0] nbits = '0;
   logic            abort = 1'b0;
   logic            ser;
   logic            rd_bit;
   logic            busy;
   logic            done;
   logic [15:0]     dout;
   logic            dout_valid;
   logic            dout_rd = 1'b0;
   logic [2:0]      level;
   logic [15:0]     csum;

   gps_ser_gather #(.DEPTH(DEPTH), .NB_W(NB_W)) dut (
      .clk(clk), .rst(rst), .start(start), .nbits(nbits),
      .abort(abort), .ser(ser), .rd_bit(rd_bit), .busy(busy),
      .done(done), .dout(dout), .dout_valid(dout_valid),
      .dout_rd(dout_rd), .level(level), .csum(csum)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // GPS source model: bit i of the stream sits at src_bits[i],
   // and advances on every edge where rd_bit is high.
   logic        src_bits [4096];
   int          src_base = 0;
   int          cyc = 0;
   int          nrd_total = 0;
   int          done_cnt = 0;
   int          first_rd_edge = 0;
   int          last_rd_edge = 0;
   int          done_edge = 0;
   int          xs = 0;
   logic [15:0] got [$];

   assign ser = src_bits[nrd_total % 4096];

   always @(posedge clk) begin
      if (rd_bit) begin
         if (nrd_total == src_base) first_rd_edge = cyc;
         last_rd_edge = cyc;
         nrd_total++;
      end
      if (done) begin
         done_cnt++;
         done_edge = cyc;
      end
      if (dout_rd && dout_valid) got.push_back(dout);
      cyc++;
   end

   // Reference: chunk the stream into 16-bit groups, MSB first;
   // a short final group is right-justified.
   function automatic void mk_words(input bit b[$],
                                    output logic [15:0] w[$]);
      logic [15:0] acc;
      int k;
      w = {};
      acc = 0;
      k = 0;
      foreach (b[i]) begin
         acc = {acc[14:0], b[i]};
         k++;
         if (k == 16 || i == b.size() - 1) begin
            w.push_back(acc);
            acc = 0;
            k = 0;
         end
      end
   endfunction

   task automatic start_xfer(input int n, input bit b[$]);
      @(negedge clk);
      src_base = nrd_total;
      foreach (b[i]) src_bits[(src_base + i) % 4096] = b[i];
      start = 1'b1;
      nbits = n[NB_W-1:0];
      xs = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_until_done(input int prob, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
         dout_rd = dout_valid && ($urandom_range(99) < prob);
      end
      dout_rd = 1'b0;
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!dout_valid) begin
            ok = 1'b1;
            break;
         end
         dout_rd = 1'b1;
      end
      dout_rd = 1'b0;
   endtask

   task automatic word_bits(input logic [15:0] w, inout bit b[$]);
      for (int i = 15; i >= 0; i--) b.push_back(w[i]);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({rd_bit, busy, done, dout_valid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000",
                  {rd_bit, busy, done, dout_valid});
      end
      n_tests++;
      if (level !== 3'd0 || dout !== 16'h0 || csum !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_data: level %0d dout %h csum %h want 0",
                  level, dout, csum);
      end
      rst = 1'b0;
   endtask

   task automatic test_fixed16;
      bit b[$];
      bit ok;
      int d0;
      b = {};
      word_bits(16'hA5C3, b);
      d0 = done_cnt;
      start_xfer(16, b);
      run_until_done(0, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL fixed_timeout: got no done want done");
      end
      n_tests++;
      if (dout !== 16'hA5C3 || level !== 3'd1) begin
         n_fail++;
         $display("FAIL fixed_word: got %h/%0d want a5c3/1",
                  dout, level);
      end
      n_tests++;
      if (first_rd_edge != xs + 1 || last_rd_edge != xs + 16 ||
          nrd_total - src_base != 16) begin
         n_fail++;
         $display("FAIL fixed_rdbit: got %0d..%0d n=%0d want %0d..%0d n=16",
                  first_rd_edge, last_rd_edge, nrd_total - src_base,
                  xs + 1, xs + 16);
      end
      @(negedge clk);
      n_tests++;
      if (done_edge != xs + 17 || done_cnt != d0 + 1) begin
         n_fail++;
         $display("FAIL fixed_done: got edge %0d cnt %0d want %0d %0d",
                  done_edge, done_cnt - d0, xs + 17, 1);
      end
      drain(ok);
   endtask

   task automatic test_partial20;
      bit b[$];
      bit ok;
      int gb;
      logic [15:0] ew[$];
      b = {};
      word_bits(16'h1234, b);
      b.push_back(1); b.push_back(0);
      b.push_back(1); b.push_back(1);
      mk_words(b, ew);
      gb = got.size();
      start_xfer(20, b);
      run_until_done(0, ok);
      @(negedge clk);
      n_tests++;
      if (!ok || done_edge != xs + 21) begin
         n_fail++;
         $display("FAIL part_done: got edge %0d want %0d",
                  done_edge, xs + 21);
      end
      drain(ok);
      n_tests++;
      if (got.size() - gb != 2 || got[gb] !== 16'h1234 ||
          got[gb+1] !== 16'h000B) begin
         n_fail++;
         $display("FAIL part_words: got n=%0d want 1234,000b",
                  got.size() - gb);
      end
      n_tests++;
      if (ew[1] !== 16'h000B) begin
         n_fail++;
         $display("FAIL part_model: got %h want 000b", ew[1]);
      end
   endtask

   task automatic test_stall;
      bit b[$];
      bit ok;
      int gb;
      logic [15:0] ew[$];
      b = {};
      for (int i = 0; i < 96; i++) b.push_back($urandom_range(1));
      mk_words(b, ew);
      gb = got.size();
      start_xfer(96, b);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (level == 3'd4) begin
            n_tests++;
            if (rd_bit !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_drop: got rd_bit %b want 0", rd_bit);
            end
         end
         if (busy && !rd_bit) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_tests++;
      if (!ok || nrd_total - src_base != 64 || level !== 3'd4) begin
         n_fail++;
         $display("FAIL stall_count: got %0d bits lvl %0d want 64/4",
                  nrd_total - src_base, level);
      end
      repeat (3) @(negedge clk);
      dout_rd = 1'b1;
      @(negedge clk);
      dout_rd = 1'b0;
      n_tests++;
      if (rd_bit !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_resume: got rd_bit %b want 1", rd_bit);
      end
      run_until_done(100, ok);
      drain(ok);
      n_tests++;
      if (got.size() - gb != 6 || nrd_total - src_base != 96) begin
         n_fail++;
         $display("FAIL stall_n: got %0d words %0d bits want 6/96",
                  got.size() - gb, nrd_total - src_base);
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (got[gb+i] !== ew[i]) begin
               n_fail++;
               $display("FAIL stall_word%0d: got %h want %h",
                        i, got[gb+i], ew[i]);
            end
         end
      end
   endtask

   task automatic test_ignore_start;
      bit b[$];
      bit ok;
      int gb;
      int d0;
      logic [15:0] ew[$];
      @(negedge clk);
      start = 1'b1;
      nbits = '0;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if ({rd_bit, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_start: got %b want 000",
                     {rd_bit, busy, done});
         end
         @(negedge clk);
      end
      b = {};
      for (int i = 0; i < 24; i++) b.push_back($urandom_range(1));
      mk_words(b, ew);
      gb = got.size();
      start_xfer(24, b);
      for (int i = 0; i < 50; i++) begin
         if (nrd_total - src_base >= 5) break;
         @(negedge clk);
      end
      start = 1'b1;
      nbits = 10'd8;
      @(negedge clk);
      start = 1'b0;
      run_until_done(100, ok);
      drain(ok);
      n_tests++;
      if (nrd_total - src_base != 24 || done_cnt != d0 + 1) begin
         n_fail++;
         $display("FAIL restart_bits: got %0d bits %0d done want 24/1",
                  nrd_total - src_base, done_cnt - d0);
      end
      n_tests++;
      if (got.size() - gb != 2 || got[gb] !== ew[0] ||
          got[gb+1] !== ew[1]) begin
         n_fail++;
         $display("FAIL restart_words: got n=%0d want %h,%h",
                  got.size() - gb, ew[0], ew[1]);
      end
   endtask

   task automatic test_reset_mid;
      bit b[$];
      bit ok;
      int gb;
      logic [15:0] ew[$];
      b = {};
      for (int i = 0; i < 32; i++) b.push_back($urandom_range(1));
      start_xfer(32, b);
      for (int i = 0; i < 50; i++) begin
         if (nrd_total - src_base >= 7) break;
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (rd_bit !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_rdbit: got %b want 0", rd_bit);
      end
      @(negedge clk);
      n_tests++;
      if ({busy, dout_valid} !== 2'b00 || level !== 3'd0 ||
          nrd_total - src_base != 7) begin
         n_fail++;
         $display("FAIL rstmid_state: got %b lvl %0d bits %0d want 00/0/7",
                  {busy, dout_valid}, level, nrd_total - src_base);
      end
      rst = 1'b0;
      b = {};
      for (int i = 0; i < 16; i++) b.push_back($urandom_range(1));
      mk_words(b, ew);
      gb = got.size();
      start_xfer(16, b);
      run_until_done(50, ok);
      drain(ok);
      n_tests++;
      if (got.size() - gb != 1 || got[gb] !== ew[0]) begin
         n_fail++;
         $display("FAIL rstmid_after: got n=%0d want %h",
                  got.size() - gb, ew[0]);
      end
   endtask

   task automatic test_csum;
      bit b[$];
      bit ok;
      logic [15:0] ec;
      b = {};
      word_bits(16'h1234, b);
      word_bits(16'h00FF, b);
`ifdef GPS_SER_GATHER_CSUM_EN
      ec = 16'h12CB;
`else
      ec = 16'h0000;
`endif
      start_xfer(32, b);
      run_until_done(0, ok);
      n_tests++;
      if (csum !== ec || level !== 3'd2) begin
         n_fail++;
         $display("FAIL csum_val: got %h lvl %0d want %h lvl 2",
                  csum, level, ec);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_tests++;
      if (csum !== 16'h0 || level !== 3'd0 || dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL csum_abort: got %h lvl %0d v %b want 0/0/0",
                  csum, level, dout_valid);
      end
   endtask

   task automatic test_random;
      bit b[$];
      bit ok;
      int gb;
      int n;
      int d0;
      logic [15:0] ew[$];
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, 100);
         b = {};
         for (int i = 0; i < n; i++) b.push_back($urandom_range(1));
         mk_words(b, ew);
         gb = got.size();
         d0 = done_cnt;
         start_xfer(n, b);
         run_until_done($urandom_range(20, 100), ok);
         drain(ok);
         n_tests++;
         if (got.size() - gb != ew.size() || done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL rand_n%0d: got %0d words want %0d",
                     t, got.size() - gb, ew.size());
         end else begin
            foreach (ew[i]) begin
               n_tests++;
               if (got[gb+i] !== ew[i]) begin
                  n_fail++;
                  $display("FAIL rand_w%0d_%0d: got %h want %h",
                           t, i, got[gb+i], ew[i]);
               end
            end
         end
      end
   endtask

   initial begin
      foreach (src_bits[i]) src_bits[i] = 1'b0;
      test_reset();
      test_fixed16();
      test_partial20();
      test_stall();
      test_ignore_start();
      test_reset_mid();
      test_csum();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
